// File: rtl/poly_pitch_generator.sv
// Polyphonic square-wave pitch generator: NUM_VOICES independent voices driven from an
// equal-tempered period table, note changes applied only at wave-cycle boundaries.
module poly_pitch_generator #(
  parameter int NUM_VOICES = 4,
  parameter int CNT_W      = 23,
  localparam int MIX_W     = $clog2(NUM_VOICES + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_VOICES-1:0]   load,
  input  logic [4*NUM_VOICES-1:0] note,
  input  logic [4*NUM_VOICES-1:0] octave,
  input  logic [2*NUM_VOICES-1:0] duty,
  output logic [NUM_VOICES-1:0]   wave,
  output logic [NUM_VOICES-1:0]   active,
  output logic [NUM_VOICES-1:0]   busy,
  output logic [MIX_W-1:0]        mix
);

  // Voice FSM; active[i] is a direct view of voice i's state (PLAY = 1).
  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} voice_state_e;

  // Octave-0 period in clk cycles for C..B; anything else is a rest.
  function automatic logic [CNT_W-1:0] base_period(input logic [3:0] n);
    logic [CNT_W-1:0] b;
    case (n)
      4'd1:    b = CNT_W'(6115609);
      4'd2:    b = CNT_W'(5772372);
      4'd3:    b = CNT_W'(5448403);
      4'd4:    b = CNT_W'(5142604);
      4'd5:    b = CNT_W'(4853968);
      4'd6:    b = CNT_W'(4581524);
      4'd7:    b = CNT_W'(4324380);
      4'd8:    b = CNT_W'(4081682);
      4'd9:    b = CNT_W'(3852599);
      4'd10:   b = CNT_W'(3636364);
      4'd11:   b = CNT_W'(3432275);
      4'd12:   b = CNT_W'(3239632);
      default: b = '0;
    endcase
    return b;
  endfunction

  function automatic logic is_tone(input logic [3:0] n);
    return (n >= 4'd1) && (n <= 4'd12);
  endfunction

  function automatic logic [CNT_W-1:0] calc_period(input logic [3:0] n, input logic [3:0] o);
    logic [3:0] oc;
    oc = (o > 4'd9) ? 4'd9 : o;
    return base_period(n) >> oc;
  endfunction

  function automatic logic [CNT_W-1:0] calc_thr(input logic [CNT_W-1:0] p, input logic [1:0] d);
    logic [CNT_W-1:0] t;
    case (d)
      2'd0:    t = p >> 1;
      2'd1:    t = p >> 2;
      2'd2:    t = p >> 3;
      default: t = p - (p >> 2);
    endcase
    return t;
  endfunction

  // Request handshake: load is a one-cycle strobe that is always accepted. An idle voice
  // applies it at once; a playing voice parks it and raises busy until the wrap edge.
  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic             busy_q, busy_d;
    logic             wave_q, wave_d;
    logic [3:0]       pnote_q, pnote_d;
    logic [3:0]       poct_q, poct_d;
    logic [1:0]       pduty_q, pduty_d;
    logic             apply;
    logic [3:0]       a_note, a_oct;
    logic [1:0]       a_duty;
    logic             ld;
    logic [3:0]       in_note, in_oct;
    logic [1:0]       in_duty;

    assign ld      = load[v];
    assign in_note = note[4*v +: 4];
    assign in_oct  = octave[4*v +: 4];
    assign in_duty = duty[2*v +: 2];

    always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      thr_d    = thr_q;
      busy_d   = busy_q;
      pnote_d  = pnote_q;
      poct_d   = poct_q;
      pduty_d  = pduty_q;
      apply    = 1'b0;
      a_note   = in_note;
      a_oct    = in_oct;
      a_duty   = in_duty;
      if (state_q == IDLE) begin
        apply = ld;
      end else if (cnt_q == period_q - CNT_W'(1)) begin
        // Wrap edge: a live request beats a parked one.
        busy_d = 1'b0;
        if (ld) begin
          apply = 1'b1;
        end else if (busy_q) begin
          apply  = 1'b1;
          a_note = pnote_q;
          a_oct  = poct_q;
          a_duty = pduty_q;
        end else begin
          cnt_d = '0;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        if (ld) begin
          busy_d  = 1'b1;
          pnote_d = in_note;
          poct_d  = in_oct;
          pduty_d = in_duty;
        end
      end
      if (apply) begin
        cnt_d = '0;
        if (is_tone(a_note)) begin
          state_d  = PLAY;
          period_d = calc_period(a_note, a_oct);
          thr_d    = calc_thr(period_d, a_duty);
        end else begin
          state_d = IDLE;
        end
      end
      wave_d = (state_q == PLAY) && (cnt_q < thr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        period_q <= '0;
        thr_q    <= '0;
        busy_q   <= 1'b0;
        wave_q   <= 1'b0;
        pnote_q  <= '0;
        poct_q   <= '0;
        pduty_q  <= '0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        period_q <= period_d;
        thr_q    <= thr_d;
        busy_q   <= busy_d;
        wave_q   <= wave_d;
        pnote_q  <= pnote_d;
        poct_q   <= poct_d;
        pduty_q  <= pduty_d;
      end
    end

    assign wave[v]   = wave_q;
    assign active[v] = (state_q == PLAY);
    assign busy[v]   = busy_q;
  end

  logic [MIX_W-1:0] mix_q, mix_d;

  always_comb begin
    mix_d = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_d = mix_d + MIX_W'(wave[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mix_q <= '0;
    end else begin
      mix_q <= mix_d;
    end
  end

  assign mix = mix_q;

endmodule
